temperature_averager: RTL and testbench

- Parametrised block-average unit for the temperature calculator path.
- Accepts a stream of unsigned samples, accumulates windows of 2^LOG2_N samples, and emits each window's mean through a valid/ready output register.
- Generalises the fixed divide-by-64 shift to configurable width and window size, with optional rounding.
- Sits between the sensor sample capture logic and the temperature conversion stage.

---
 rtl/temperature_averager.sv | 74 +++++++
 tb/tb_temperature_averager.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/temperature_averager.sv
// Block-average unit: sums windows of 2^LOG2_N unsigned samples and registers each window's mean.
// Build option: define TEMP_AVG_ROUND_EN for round-half-up results; otherwise the mean is truncated (floor).
module temperature_averager #(
    parameter int DATA_W = 32,
    parameter int LOG2_N = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LOG2_N-1:0] sample_cnt
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_CNT = '1;
`ifdef TEMP_AVG_ROUND_EN
    localparam logic [ACC_W-1:0] ROUND_ADD = ACC_W'(1) << (LOG2_N - 1);
`else
    localparam logic [ACC_W-1:0] ROUND_ADD = '0;
`endif

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] result_sum;
    logic             last_slot;
    logic             accept;
    logic             out_take;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // The producer holds valid/data until that edge; ready never depends on the same side's valid.
    assign last_slot  = (sample_cnt == LAST_CNT);
    assign in_ready   = !clear && !(last_slot && out_valid && !out_ready);
    assign accept     = in_valid && in_ready;
    assign out_take   = out_valid && out_ready;

    // Rounding is added only when the window closes so the running sum stays exact.
    assign sum        = acc + ACC_W'(in_data);
    assign result_sum = sum + ROUND_ADD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            sample_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (out_take) begin
                out_valid <= 1'b0;
            end

            if (clear) begin
                acc        <= '0;
                sample_cnt <= '0;
            end else if (accept) begin
                if (last_slot) begin
                    // A new result overrides the clear from a same-cycle consumer handshake.
                    out_data   <= DATA_W'(result_sum >> LOG2_N);
                    out_valid  <= 1'b1;
                    acc        <= '0;
                    sample_cnt <= '0;
                end else begin
                    acc        <= sum;
                    sample_cnt <= sample_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_temperature_averager.sv
// Randomised bench for temperature_averager against a queue-based window-mean reference model.
module tb_temperature_averager;

    localparam int DATA_W = 32;
    localparam int LOG2_N = 6;
    localparam int N      = 1 << LOG2_N;
`ifdef TEMP_AVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              clear     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data   = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [LOG2_N-1:0] sample_cnt;

    temperature_averager #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sample_cnt (sample_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model and scoreboard ----------------
    logic [DATA_W-1:0] win[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_data  = '0;
    int                total   = 0;
    int                bad     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] window_mean();
        logic [63:0] s = 64'd0;
        foreach (win[i]) s += 64'(win[i]);
        if (ROUND) s += 64'(N / 2);
        return DATA_W'(s / 64'(N));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic clr,
                        input logic ordy, output logic acc);
        logic exp_ready;
        in_valid  = v;
        in_data   = d;
        clear     = clr;
        out_ready = ordy;
        @(negedge clk);
        exp_ready = !clr && !(win.size() == N - 1 && m_valid && !ordy);
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("sample_cnt", 64'(sample_cnt), 64'(win.size()));
        acc = v && exp_ready;
        if (m_valid && ordy) begin
            if (exp_q.size() > 0) check("hs_data", 64'(out_data), 64'(exp_q.pop_front()));
            m_valid = 1'b0;
        end
        if (clr) begin
            win.delete();
        end else if (acc) begin
            win.push_back(d);
            if (win.size() == N) begin
                m_data  = window_mean();
                m_valid = 1'b1;
                exp_q.push_back(m_data);
                win.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic ordy);
        logic a = 1'b0;
        for (int t = 0; t < 200 && !a; t++) step(1'b1, d, 1'b0, ordy, a);
        check("send_accepted", 64'(a), 64'd1);
    endtask

    task automatic idle(input logic ordy);
        logic a;
        step(1'b0, '0, 1'b0, ordy, a);
    endtask

    task automatic async_reset();
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_sample_cnt", 64'(sample_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        win.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic a;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_sample_cnt", 64'(sample_cnt), 64'd0);

        // Constant window of 100.
        for (int i = 0; i < N; i++) send(DATA_W'(100), 1'b1);
        check("const_valid", 64'(out_valid), 64'd1);
        check("const_mean", 64'(out_data), 64'd100);
        check("const_cnt", 64'(sample_cnt), 64'd0);
        idle(1'b1);
        idle(1'b1);

        // Ramp 0..63: sum 2016, floor 31, rounded 32.
        for (int i = 0; i < N; i++) send(DATA_W'(i), 1'b1);
        check("ramp_mean", 64'(out_data), ROUND ? 64'd32 : 64'd31);
        idle(1'b1);

        // All-ones samples must not overflow.
        for (int i = 0; i < N; i++) send('1, 1'b1);
        check("max_mean", 64'(out_data), 64'hFFFF_FFFF);
        idle(1'b1);

        // Back-pressure: result 5 held while the next window's last sample stalls.
        for (int i = 0; i < N; i++) send(DATA_W'(5), 1'b0);
        for (int i = 0; i < N - 1; i++) send(DATA_W'(7), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, DATA_W'(7), 1'b0, 1'b0, a);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("held_mean5", 64'(out_data), 64'd5);
        check("stall_cnt", 64'(sample_cnt), 64'(N - 1));
        step(1'b1, DATA_W'(7), 1'b0, 1'b1, a);
        check("reload_valid", 64'(out_valid), 64'd1);
        check("reload_mean7", 64'(out_data), 64'd7);
        idle(1'b1);
        check("drained_valid", 64'(out_valid), 64'd0);

        // Clear drops the partial window and the sample offered during clear.
        for (int i = 0; i < 10; i++) send($urandom, 1'b1);
        step(1'b1, DATA_W'(1000), 1'b1, 1'b1, a);
        check("clear_cnt", 64'(sample_cnt), 64'd0);
        for (int i = 0; i < N; i++) send(DATA_W'(9), 1'b1);
        check("clear_mean", 64'(out_data), 64'd9);
        idle(1'b1);

        // Asynchronous reset mid-window with a result pending.
        for (int i = 0; i < N; i++) send(DATA_W'(4), 1'b0);
        for (int i = 0; i < 30; i++) send(DATA_W'(2), 1'b0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_cnt", 64'(sample_cnt), 64'd30);
        async_reset();
        for (int i = 0; i < N; i++) send(DATA_W'(3), 1'b1);
        check("post_rst_mean", 64'(out_data), 64'd3);
        idle(1'b1);

        // Random traffic: mixed valid, clear and back-pressure.
        for (int i = 0; i < 3000; i++) begin
            logic [DATA_W-1:0] d;
            d = ($urandom_range(0, 1) == 0) ? DATA_W'($urandom_range(0, 255)) : DATA_W'($urandom);
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0, a);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
